// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
// lbp_pkg : shared types, neighbour bit positions and the LBP code function
//           for the streaming Local Binary Pattern engine.
// Revision : 1.0
// ============================================================================
package lbp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DRAIN  = 3'd2,
    BORDER = 3'd3,
    DONE   = 3'd4
  } lbp_state_e;

  // Code bit positions of each neighbour
  localparam int LBP_TL = 0;
  localparam int LBP_T  = 1;
  localparam int LBP_TR = 2;
  localparam int LBP_L  = 3;
  localparam int LBP_R  = 4;
  localparam int LBP_BL = 5;
  localparam int LBP_B  = 6;
  localparam int LBP_BR = 7;

  // Widest supported pixel; narrower pixels are zero-extended into the window
  localparam int LBP_PIX_MAX_W = 16;

  // 3x3 window, row-major: index = row*3 + col, centre at index 4
  typedef logic [8:0][LBP_PIX_MAX_W-1:0] lbp_win_t;

  function automatic logic [7:0] lbp_code(input lbp_win_t w);
    logic [7:0] c;
    c[LBP_TL] = (w[0] >= w[4]);
    c[LBP_T]  = (w[1] >= w[4]);
    c[LBP_TR] = (w[2] >= w[4]);
    c[LBP_L]  = (w[3] >= w[4]);
    c[LBP_R]  = (w[5] >= w[4]);
    c[LBP_BL] = (w[6] >= w[4]);
    c[LBP_B]  = (w[7] >= w[4]);
    c[LBP_BR] = (w[8] >= w[4]);
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lbp_line_buf.sv
`default_nettype none
// ============================================================================
// lbp_line_buf : two row-delay buffers plus 3x3 window registers; presents the
//                window centred one row/column behind each captured pixel.
// Revision : 1.0
// ============================================================================
module lbp_line_buf
  import lbp_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_i,
  input  logic [PIX_W-1:0] pix_i,
  output lbp_win_t         win_o,
  output logic             win_valid_o
);

  localparam int             COL_W    = $clog2(IMG_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  logic [PIX_W-1:0] lb_top_q [IMG_W];  // row r-2
  logic [PIX_W-1:0] lb_mid_q [IMG_W];  // row r-1
  logic [PIX_W-1:0] west_q [3];        // column c-2, top..bottom
  logic [PIX_W-1:0] cent_q [3];        // column c-1, top..bottom
  logic [PIX_W-1:0] top_new, mid_new;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       rows_q, rows_d;

  assign top_new = lb_top_q[col_q];
  assign mid_new = lb_mid_q[col_q];

  always_ff @(posedge clk) begin
    if (cap_i) begin
      lb_top_q[col_q] <= mid_new;
      lb_mid_q[col_q] <= pix_i;
    end
  end

  always_comb begin
    col_d  = col_q;
    rows_d = rows_q;
    if (cap_i) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (rows_q != 2'd2) rows_d = rows_q + 2'd1;
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      rows_q <= '0;
      for (int i = 0; i < 3; i++) begin
        west_q[i] <= '0;
        cent_q[i] <= '0;
      end
    end else begin
      col_q  <= col_d;
      rows_q <= rows_d;
      if (cap_i) begin
        cent_q[0] <= top_new;
        cent_q[1] <= mid_new;
        cent_q[2] <= pix_i;
        // A new row starts with an empty window so nothing wraps from the previous row
        for (int i = 0; i < 3; i++) west_q[i] <= (col_q == '0) ? '0 : cent_q[i];
      end
    end
  end

  always_comb begin
    win_o    = '0;
    win_o[0] = LBP_PIX_MAX_W'(west_q[0]);
    win_o[1] = LBP_PIX_MAX_W'(cent_q[0]);
    win_o[2] = LBP_PIX_MAX_W'(top_new);
    win_o[3] = LBP_PIX_MAX_W'(west_q[1]);
    win_o[4] = LBP_PIX_MAX_W'(cent_q[1]);
    win_o[5] = LBP_PIX_MAX_W'(mid_new);
    win_o[6] = LBP_PIX_MAX_W'(west_q[2]);
    win_o[7] = LBP_PIX_MAX_W'(cent_q[2]);
    win_o[8] = LBP_PIX_MAX_W'(pix_i);
  end

  assign win_valid_o = cap_i && (rows_q == 2'd2) && (col_q >= COL_W'(2));

endmodule
`default_nettype wire

// File: rtl/lbp_stream_engine.sv
`default_nettype none
// ============================================================================
// lbp_stream_engine : raster-order frame reader producing one LBP code per
//                     interior pixel. Optional LBP_BORDER_EN zero-fills border.
// Revision : 1.0
// ============================================================================
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFS   = ADDR_W'(IMG_W + 1);

  lbp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cap_addr_q;
  logic              cap_valid_q;
  logic              lbp_valid_q, lbp_valid_d;
  logic [ADDR_W-1:0] lbp_addr_q, lbp_addr_d;
  logic [7:0]        lbp_data_q, lbp_data_d;
  lbp_win_t          win;
  logic              win_valid;
  logic              border_last;

  lbp_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_line_buf (
    .clk         (clk),
    .reset       (reset),
    .cap_i       (cap_valid_q),
    .pix_i       (gray_data),
    .win_o       (win),
    .win_valid_o (win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (gray_ready) state_d = READ;
      READ:   if (gray_ready && addr_q == LAST_ADDR) state_d = DRAIN;
`ifdef LBP_BORDER_EN
      DRAIN:  if (!cap_valid_q) state_d = BORDER;
`else
      DRAIN:  if (!cap_valid_q) state_d = DONE;
`endif
      BORDER: if (border_last) state_d = DONE;
      DONE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gray_req = (state_q == READ) && gray_ready;
    finish   = (state_q == DONE);
  end

`ifdef LBP_BORDER_EN
  localparam int               COL_W    = $clog2(IMG_W);
  localparam int               ROW_W    = $clog2(IMG_H);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [COL_W-1:0]  bcol_q, bcol_d;
  logic [ROW_W-1:0]  brow_q, brow_d;
  logic              bdone_q, bdone_d;
  logic              edge_row;

  assign edge_row    = (brow_q == '0) || (brow_q == LAST_ROW);
  assign border_last = bdone_q;

  // Walks border addresses in ascending order: full rows at top/bottom, two columns between
  always_comb begin
    baddr_d = baddr_q;
    bcol_d  = bcol_q;
    brow_d  = brow_q;
    bdone_d = bdone_q;
    if (state_q == BORDER && !bdone_q) begin
      if (brow_q == LAST_ROW && bcol_q == LAST_COL) begin
        bdone_d = 1'b1;
      end else if (edge_row && bcol_q != LAST_COL) begin
        bcol_d  = bcol_q + COL_W'(1);
        baddr_d = baddr_q + ADDR_W'(1);
      end else if (!edge_row && bcol_q == '0) begin
        bcol_d  = LAST_COL;
        baddr_d = baddr_q + ADDR_W'(IMG_W - 1);
      end else begin
        bcol_d  = '0;
        brow_d  = brow_q + ROW_W'(1);
        baddr_d = baddr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baddr_q <= '0;
      bcol_q  <= '0;
      brow_q  <= '0;
      bdone_q <= 1'b0;
    end else begin
      baddr_q <= baddr_d;
      bcol_q  <= bcol_d;
      brow_q  <= brow_d;
      bdone_q <= bdone_d;
    end
  end
`else
  assign border_last = 1'b0;
`endif

  always_comb begin
    addr_d      = gray_req ? addr_q + ADDR_W'(1) : addr_q;
    lbp_valid_d = win_valid;
    lbp_addr_d  = cap_addr_q - CTR_OFS;
    lbp_data_d  = lbp_code(win);
`ifdef LBP_BORDER_EN
    if (state_q == BORDER && !bdone_q) begin
      lbp_valid_d = 1'b1;
      lbp_addr_d  = baddr_q;
      lbp_data_d  = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
    end else begin
      addr_q      <= addr_d;
      cap_valid_q <= gray_req;
      cap_addr_q  <= addr_q;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
    end
  end

  assign gray_addr = addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lbp_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_lbp_stream_engine : scoreboard bench; a 40x20 engine against a neighbour
//                        comparison model and a 3x3 engine for exact timing.
// Revision : 1.0
// ============================================================================
module tb_lbp_stream_engine;

  localparam int W  = 40;
  localparam int H  = 20;
  localparam int N  = W * H;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready, gray_req, lbp_valid, finish;
  logic [AW-1:0] gray_addr, lbp_addr;
  logic [7:0]    gray_data, lbp_data;

  logic          s_ready, s_req, s_valid, s_finish;
  logic [3:0]    s_gaddr, s_laddr;
  logic [7:0]    s_gdata, s_ldata;

  logic [7:0] mem   [N];
  logic [7:0] mem_s [9] = '{8'd10, 8'd60, 8'd50, 8'd40, 8'd50, 8'd70, 8'd90, 8'd20, 8'd50};

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  exp_req  = 0;
  int  rdy_mode = 0;
  int  cyc      = 0;
  int  compared = 0;
  int  mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lbp_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish));

  lbp_stream_engine #(.IMG_W(3), .IMG_H(3), .PIX_W(8), .ADDR_W(4)) u_small (
    .clk(clk), .reset(reset), .gray_ready(s_ready), .gray_req(s_req),
    .gray_addr(s_gaddr), .gray_data(s_gdata), .lbp_valid(s_valid),
    .lbp_addr(s_laddr), .lbp_data(s_ldata), .finish(s_finish));

  // Host memories with one-cycle read latency
  always @(posedge clk) if (gray_req) gray_data <= mem[gray_addr];
  always @(posedge clk) if (s_req)    s_gdata   <= mem_s[s_gaddr];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: compare each interior pixel with its eight neighbours
  function automatic void build_expect();
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        int code = 0;
        for (int b = 0; b < 8; b++)
          if (mem[(r + dr[b]) * W + c + dc[b]] >= mem[r * W + c]) code |= (1 << b);
        exp_q.push_back('{addr: r * W + c, data: code});
      end
`ifdef LBP_BORDER_EN
    for (int a = 0; a < N; a++)
      if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1)
        exp_q.push_back('{addr: a, data: 0});
`endif
  endfunction

  // Ready driver: 0 low, 1 high, 2 toggle every cycle, 3 random
  initial begin
    gray_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       gray_ready = 1'b0;
        1:       gray_ready = 1'b1;
        2:       gray_ready = ~gray_ready;
        default: gray_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: request order and scoreboard of writes
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (gray_req) begin
          check("req_addr", int'(gray_addr), exp_req);
          exp_req++;
        end
        if (lbp_valid) begin
          if (exp_q.size() == 0) begin
            check("extra_write_addr", int'(lbp_addr), -1);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", int'(lbp_addr), e.addr);
            check("wr_data", int'(lbp_data), e.data);
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"},   int'(gray_req), 0);
    check({tag, "_gaddr"}, int'(gray_addr), 0);
    check({tag, "_valid"}, int'(lbp_valid), 0);
    check({tag, "_laddr"}, int'(lbp_addr), 0);
    check({tag, "_ldata"}, int'(lbp_data), 0);
    check({tag, "_finish"}, int'(finish), 0);
  endtask

  task automatic run_frame(input int mode, input int abort_at);
    int k;
    reset = 1'b1;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_req = 0;
    build_expect();
    reset = 1'b0;
    rdy_mode = mode;
    if (abort_at >= 0) begin
      k = 0;
      while (!(gray_req && int'(gray_addr) == abort_at) && k < 4 * N) begin
        @(negedge clk);
        k++;
      end
      check("abort_point", int'(gray_addr), abort_at);
      reset = 1'b1;
      @(negedge clk);
      check_zero_outputs("abort");
      exp_q.delete();
      exp_req = 0;
      build_expect();
      reset = 1'b0;
    end
    k = 0;
    while (!finish && k < 6 * N) begin
      @(negedge clk);
      k++;
    end
    check("finish_rise", int'(finish), 1);
    check("writes_left", exp_q.size(), 0);
    check("req_count", exp_req, N);
    repeat (3) @(negedge clk);
    check("finish_held", int'(finish), 1);
    check("done_quiet", int'(gray_req | lbp_valid), 0);
    rdy_mode = 0;
  endtask

  task automatic run_small();
    int t0 = -1, tv = -1, tf = -1, nw = 0, nr = 0, k = 0;
    int a1 = -1, d1 = -1;
    s_ready = 1'b1;
    while (tf < 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (s_req) begin
        nr++;
        if (t0 < 0) t0 = cyc;
      end
      if (s_valid) begin
        nw++;
        if (nw == 1) begin
          tv = cyc;
          a1 = int'(s_laddr);
          d1 = int'(s_ldata);
        end
      end
      if (s_finish) tf = cyc;
    end
    s_ready = 1'b0;
    check("small_reqs", nr, 9);
    check("small_first_addr", a1, 4);
    check("small_first_data", d1, 'hB6);
    check("small_valid_cycle", tv - t0, 10);
`ifdef LBP_BORDER_EN
    check("small_writes", nw, 9);
    check("small_finish_cycle", tf - t0, 20);
`else
    check("small_writes", nw, 1);
    check("small_finish_cycle", tf - t0, 11);
`endif
  endtask

  initial begin
    reset   = 1'b1;
    s_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    run_small();

    for (int i = 0; i < N; i++) mem[i] = 8'h55;
    run_frame(1, -1);

    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    run_frame(1, -1);
    run_frame(2, -1);

    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 7));
    run_frame(3, -1);

    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    run_frame(1, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
